// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for six writeback sources onto one shared writeback mux.
// Optional per-owner hold limit is enabled by defining ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] req,
  output logic [5:0] grant,
  output logic [2:0] select,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t     state, next_state;
  logic [2:0] owner, next_owner;
  logic [2:0] last_owner, next_last;
  logic [2:0] pick;
  logic [3:0] cand;
  logic       found;
  logic       arb_point;
  logic       excl;
  logic [5:0] next_grant;

  if (HOLD_MAX < 2) begin : g_bad_hold
    $error("wb_bus_arbiter: HOLD_MAX must be at least 2");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Forced rotation: owner has used its budget and someone else is waiting.
  assign excl = (state == OWN) && (hold_cnt == CNT_LAST) && (|(req & ~grant));

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (arb_point && found) begin
      hold_cnt <= '0;
    end else if ((state == OWN) && (hold_cnt != CNT_LAST)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign excl = 1'b0;
`endif

  assign arb_point = (state == IDLE) || !req[owner] || excl;

  // Scan starts just past last_owner, so the previous owner is naturally last.
  always_comb begin
    found = 1'b0;
    pick  = last_owner;
    cand  = '0;
    for (int unsigned i = 1; i <= 6; i++) begin
      cand = {1'b0, last_owner} + 4'(i);
      if (cand >= 4'd6) begin
        cand = cand - 4'd6;
      end
      if (!found && req[cand[2:0]] && !(excl && (cand[2:0] == owner))) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  always_comb begin
    next_state = state;
    next_owner = owner;
    next_last  = last_owner;
    next_grant = '0;
    if (arb_point) begin
      if (found) begin
        next_state = OWN;
        next_owner = pick;
        next_last  = pick;
      end else begin
        next_state = IDLE;
      end
    end
    if (next_state == OWN) begin
      next_grant = 6'(1) << next_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 3'd5;
      last_owner <= 3'd5;
      grant      <= '0;
      select     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      owner      <= next_owner;
      last_owner <= next_last;
      grant      <= next_grant;
      select     <= (next_state == OWN) ? next_owner + 3'd1 : 3'b000;
      busy       <= (next_state == OWN);
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: expected grants are queued with each
// stimulus cycle and checked one cycle later together with select and busy.
module tb_wb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] req;
  logic [5:0] grant;
  logic [2:0] select;
  logic       busy;

  logic [5:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  wb_bus_arbiter #(.HOLD_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .select(select),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] sel_of(input logic [5:0] g);
    sel_of = 3'b000;
    for (int i = 0; i < 6; i++) begin
      if (g[i]) sel_of = 3'(i + 1);
    end
  endfunction

  task automatic apply(input logic rst, input logic [5:0] r, input logic [5:0] e);
    reset = rst;
    req   = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] e;
    logic [9:0] want;
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, (k == 0) ? 6'b111111 : 6'b010000, 6'b000000);
      e    = exp_q.pop_front();
      want = {e, sel_of(e), |e};
      compared++;
      if ({grant, select, busy} !== want) begin
        mismatched++;
        $display("FAIL reset[%0d]: got grant=%b select=%b busy=%b, required %b", k, grant, select, busy, want);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [5:0] reqs [0:12];
    logic [5:0] exps [0:12];
    logic [5:0] e;
    logic [9:0] want;
    reqs = '{6'b000001, 6'b100101, 6'b100101, 6'b100101, 6'b100100, 6'b100000, 6'b100001,
             6'b000001, 6'b000000, 6'b010000, 6'b000000, 6'b010001, 6'b101010};
    exps = '{6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000100, 6'b100000, 6'b100000,
             6'b000001, 6'b000000, 6'b010000, 6'b000000, 6'b000001, 6'b000010};
    for (int k = 0; k < 13; k++) begin
      apply(1'b1, reqs[k], exps[k]);
      e    = exp_q.pop_front();
      want = {e, sel_of(e), |e};
      compared++;
      if ({grant, select, busy} !== want) begin
        mismatched++;
        $display("FAIL round_robin[%0d]: got grant=%b select=%b busy=%b, required %b", k, grant, select, busy, want);
      end
    end
  endtask

  task automatic test_hold;
    logic [5:0] e;
    logic [9:0] want;
    int n;
    apply(1'b0, 6'b000000, 6'b000000);
    void'(exp_q.pop_front());
    apply(1'b1, 6'b000100, 6'b000100);
    e = exp_q.pop_front();
    compared++;
    if (grant !== e) begin
      mismatched++;
      $display("FAIL hold_start: got grant=%b required %b", grant, e);
    end
`ifdef ARB_TIMEOUT_EN
    n = 8;
`else
    n = 55;
`endif
    for (int k = 0; k < n; k++) begin
`ifdef ARB_TIMEOUT_EN
      apply(1'b1, 6'b001100, (k < 7) ? 6'b000100 : 6'b001000);
`else
      apply(1'b1, 6'b001100, 6'b000100);
`endif
      e    = exp_q.pop_front();
      want = {e, sel_of(e), |e};
      compared++;
      if ({grant, select, busy} !== want) begin
        mismatched++;
        $display("FAIL hold[%0d]: got grant=%b select=%b busy=%b, required %b", k, grant, select, busy, want);
      end
    end
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 13; k++) begin
      apply(1'b1, (k < 12) ? 6'b001000 : 6'b001100, (k < 12) ? 6'b001000 : 6'b000100);
      e = exp_q.pop_front();
      compared++;
      if (grant !== e) begin
        mismatched++;
        $display("FAIL hold_saturate[%0d]: got grant=%b required %b", k, grant, e);
      end
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic       rsts [0:4];
    logic [5:0] reqs [0:4];
    logic [5:0] exps [0:4];
    logic [5:0] e;
    logic [9:0] want;
    rsts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reqs = '{6'b000000, 6'b010000, 6'b010000, 6'b010000, 6'b110000};
    exps = '{6'b000000, 6'b010000, 6'b010000, 6'b000000, 6'b010000};
    for (int k = 0; k < 5; k++) begin
      apply(rsts[k], reqs[k], exps[k]);
      e    = exp_q.pop_front();
      want = {e, sel_of(e), |e};
      compared++;
      if ({grant, select, busy} !== want) begin
        mismatched++;
        $display("FAIL reset_mid[%0d]: got grant=%b select=%b busy=%b, required %b", k, grant, select, busy, want);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    test_reset();
    test_round_robin();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles per owner while others wait; used only with ARB_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 req  input  6  request per writeback source; bit i = source i; held high for as long as the source needs the bus.
REQ-005 grant  output  6  registered one-hot grant; all-zero when idle.
REQ-006 select  output  3  registered select code for the shared 6:1 writeback mux; 3'b000 = idle (mux outputs zero); source i -> code i+1 (3'b001..3'b110).
REQ-007 busy  output  1  registered; high when any grant bit is set.

Function
REQ-008 The block SHALL keep two states: IDLE (no owner) and OWN (exactly one owner).
REQ-009 grant, select and busy SHALL always be consistent: grant[i]=1 implies select=i+1 and busy=1; grant=0 implies select=3'b000 and busy=0.
REQ-010 Arbitration point: state IDLE, or state OWN with req[owner]=0 in the current cycle.
REQ-011 At an arbitration point the block SHALL pick the first asserted req bit in round-robin order, starting at last_owner+1 and wrapping 5->0.
REQ-012 Grant latency SHALL be one cycle: req sampled in cycle N -> grant visible in cycle N+1.
REQ-013 If no req bit is asserted at an arbitration point, the next state SHALL be IDLE with grant=0.
REQ-014 Owner release SHALL be back-to-back: owner drops req in cycle N, another source pending -> new grant in cycle N+1, with no idle gap.
REQ-015 A previous owner that re-asserts req at an arbitration point SHALL be considered last in round-robin order; it regains the bus only if no other bit is set.
REQ-016 While in OWN with req[owner]=1 and no forced rotation (REQ-022), grant SHALL remain unchanged regardless of other requests.
REQ-017 last_owner SHALL update to the new owner index in every cycle a new grant is issued, and SHALL be unchanged while IDLE.
REQ-018 Requests arriving in the same cycle SHALL be resolved only by REQ-011; no fixed priority exists outside the round-robin pointer.

Reset
REQ-019 While reset=0 at a clock edge: state=IDLE, grant=6'b0, select=3'b000, busy=0, last_owner=5 (source 0 has first priority), hold counter=0.
REQ-020 A reset asserted mid-ownership SHALL drop the grant on the next edge; req is ignored in that cycle.
REQ-021 On the first edge after reset deasserts, arbitration SHALL follow REQ-011 using last_owner=5.

Configuration
REQ-022 ARB_TIMEOUT_EN defined: a hold counter SHALL clear on each new grant and increment each OWN cycle. When it reaches HOLD_MAX-1 while another req bit is set, the current cycle SHALL be an arbitration point excluding the owner, so the new owner is granted after exactly HOLD_MAX owner cycles. With no other requester, the counter SHALL saturate and ownership SHALL continue.
REQ-023 ARB_TIMEOUT_EN undefined: no hold counter SHALL exist; the owner keeps the bus until it drops req, and HOLD_MAX SHALL be unused.

Verification
REQ-024 Release from reset with req=6'b000001 in cycle 0 -> cycle 1: grant=6'b000001, select=3'b001, busy=1.
REQ-025 Owner 0, req=6'b100101, req[0] drops in cycle 5 -> cycle 6: grant=6'b000100, select=3'b011 (round-robin past 0, skipping 1).
REQ-026 Owner 5 (select=3'b110), req=6'b100001, req[5] drops -> next grant index 0 (wrap-around), select=3'b001.
REQ-027 All req drop while owning -> next cycle grant=0, select=3'b000, busy=0; req=6'b010000 the following cycle -> grant=6'b010000 one cycle later.
REQ-028 ARB_TIMEOUT_EN, HOLD_MAX=8: owner 2 holds req and req[3] is high throughout -> grant moves to index 3 after exactly 8 grant cycles of owner 2. Without the macro, owner 2 keeps the grant for 50+ cycles.
REQ-029 reset=0 asserted in the middle of ownership of index 4 -> next edge grant=0, select=3'b000. After reset releases with req=6'b110000, grant goes to index 4 (last_owner=5 wraps to 0..4).
